instr_encoder: RTL and testbench

Encoder/loader that packs decoded instruction fields into 32-bit ISA words and writes them sequentially into instruction memory. It is the inverse of the processor's opcode decode and immediate sign-extension path. It is used by the test harness and the boot loader to fill imem without a pre-assembled .mif. It accepts one instruction per cycle over a valid/ready handshake, checks field legality, and drives a single imem write port with an auto-incrementing address.

---
 rtl/isa_pkg.sv | 64 ++++++
 rtl/imm_narrow.sv | 17 +
 rtl/instr_encoder.sv | 212 +++++++++++++++++++++
 tb/tb_instr_encoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// isa_pkg: opcode constants, instruction field positions, format and error
// encodings, and FSM state type shared by the instruction encoder.
package isa_pkg;

    // Opcodes of the target ISA (5-bit, bits [31:27] of every word)
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    // Field LSB positions and widths inside a 32-bit instruction word
    localparam int REG_W     = 5;
    localparam int OP_LSB    = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_LSB = 2;
    localparam int IMM_W     = 17;
    localparam int TGT_W     = 27;

    // Instruction formats; FMT_BAD marks an opcode outside the ISA
    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_JI  = 3'd2,
        FMT_JII = 3'd3,
        FMT_BAD = 3'd4
    } fmt_e;

    // Error codes reported on err_code (first error since start wins)
    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_OPCODE = 2'b01;
    localparam logic [1:0] ERR_IMM    = 2'b10;
    localparam logic [1:0] ERR_TARGET = 2'b11;

    // Loader FSM states; the encoding is visible on the state_dbg port
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Map an opcode onto its instruction format
    function automatic fmt_e opcode_format(input logic [4:0] op);
        fmt_e f;
        case (op)
            OP_RTYPE:                               f = FMT_R;
            OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT:  f = FMT_I;
            OP_J, OP_JAL, OP_BEX, OP_SETX:          f = FMT_JI;
            OP_JR:                                  f = FMT_JII;
            default:                                f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_narrow.sv
// imm_narrow: narrows a 32-bit two's complement immediate to the 17-bit
// instruction field. It is the inverse of the processor's sign-extender:
// fits is high when sign-extending the narrowed value reproduces the input.
module imm_narrow
    import isa_pkg::*;
(
    input  logic [31:0]      value,
    output logic [IMM_W-1:0] narrow,
    output logic             fits
);

    // The low bits pass straight through; the discarded upper bits must all
    // equal the new sign bit for the value to be representable.
    assign narrow = value[IMM_W-1:0];
    assign fits   = (value[31:IMM_W-1] == {(32-IMM_W+1){value[IMM_W-1]}});

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 32-bit ISA words and
// writes them sequentially into instruction memory through one write port.
//
// Optional feature macro: ENC_RANGE_CHECK_EN. When defined, immediates that
// do not fit 17 signed bits and jump targets above 27 bits are flagged as
// errors and not written. When undefined they are truncated and written.
//
// Handshake: a bundle transfers on a rising clock edge where in_valid and
// in_ready are both high; in_ready never depends on in_valid, and in_valid
// without in_ready leaves the bundle untaken (the source must hold it).
// A start pulse overrides everything in its cycle, including a transfer.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              load_end,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_aluop,
    input  logic [31:0]       in_imm,
    input  logic [31:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic [ADDR_W:0]   word_cnt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = ADDR_W + 1;
    // One extra bit so count + pending can never overflow the compare
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(2 ** ADDR_W);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'((2 ** ADDR_W) - 1);

    state_e            state;
    state_e            next_state;
    logic              pend;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       data;
    logic              err_q;
    logic [1:0]        err_code_q;

    fmt_e              fmt;
    logic [31:0]       enc_word;
    logic [1:0]        enc_err;
    logic [IMM_W-1:0]  imm_field;
    logic              imm_fits;
    logic              imm_ok;
    logic              tgt_ok;
    logic              accept;
    logic              last_write;
    logic [CNT_W:0]    fill;

    // ------------------------------------------------------------------
    // Field legality
    // ------------------------------------------------------------------
    imm_narrow u_imm_narrow (
        .value  (in_imm),
        .narrow (imm_field),
        .fits   (imm_fits)
    );

`ifdef ENC_RANGE_CHECK_EN
    assign imm_ok = imm_fits;
    assign tgt_ok = (in_target[31:TGT_W] == '0);
`else
    // Range errors are disabled; over-range values are simply truncated
    logic unused_range;
    assign unused_range = ^{imm_fits, in_target[31:TGT_W]};
    assign imm_ok = 1'b1;
    assign tgt_ok = 1'b1;
`endif

    // Pack the fields for the opcode's format and classify legality
    always_comb begin
        fmt      = opcode_format(in_opcode);
        enc_word = '0;
        enc_err  = ERR_NONE;
        enc_word[OP_LSB +: REG_W] = in_opcode;
        case (fmt)
            FMT_R: begin
                enc_word[RD_LSB    +: REG_W] = in_rd;
                enc_word[RS_LSB    +: REG_W] = in_rs;
                enc_word[RT_LSB    +: REG_W] = in_rt;
                enc_word[SHAMT_LSB +: REG_W] = in_shamt;
                enc_word[ALUOP_LSB +: REG_W] = in_aluop;
            end
            FMT_I: begin
                enc_word[RD_LSB +: REG_W] = in_rd;
                enc_word[RS_LSB +: REG_W] = in_rs;
                enc_word[IMM_W-1:0]       = imm_field;
                if (!imm_ok) begin
                    enc_err = ERR_IMM;
                end
            end
            FMT_JI: begin
                enc_word[TGT_W-1:0] = in_target[TGT_W-1:0];
                if (!tgt_ok) begin
                    enc_err = ERR_TARGET;
                end
            end
            FMT_JII: begin
                enc_word[RD_LSB +: REG_W] = in_rd;
            end
            default: begin
                enc_err = ERR_OPCODE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    assign fill       = {1'b0, cnt} + {{CNT_W{1'b0}}, pend};
    assign last_write = pend && (cnt == LAST_CNT);
    assign accept     = in_valid && in_ready;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: start always re-arms; LOAD ends on load_end or when full.
    // A write pending alongside load_end completes on that same edge.
    always_comb begin
        next_state = state;
        if (start) begin
            next_state = ST_LOAD;
        end else begin
            case (state)
                ST_IDLE: next_state = ST_IDLE;
                ST_LOAD: begin
                    if (load_end || last_write) begin
                        next_state = ST_DONE;
                    end
                end
                ST_DONE: next_state = ST_DONE;
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: ready, busy, done and the state debug view
    always_comb begin
        in_ready  = (state == ST_LOAD) && !load_end && (fill < DEPTH_EXT);
        busy      = (state == ST_LOAD) || pend;
        done      = (state == ST_DONE);
        state_dbg = state;
    end

    // ------------------------------------------------------------------
    // Output stage, address/count and sticky error
    // ------------------------------------------------------------------
    // A legal accepted word is registered and written the following cycle;
    // the address and count advance as that write cycle ends.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend       <= 1'b0;
            addr       <= '0;
            cnt        <= '0;
            data       <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else if (start) begin
            pend       <= 1'b0;
            addr       <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            if (pend) begin
                addr <= addr + 1'b1;
                cnt  <= cnt + 1'b1;
            end
            pend <= accept && (enc_err == ERR_NONE);
            if (accept && (enc_err == ERR_NONE)) begin
                data <= enc_word;
            end
            if (accept && (enc_err != ERR_NONE)) begin
                err_q <= 1'b1;
                if (!err_q) begin
                    err_code_q <= enc_err;
                end
            end
        end
    end

    assign imem_we   = pend;
    assign imem_addr = addr;
    assign imem_data = data;
    assign word_cnt  = cnt;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a full-size instance (ADDR_W=12) and a
// small one (ADDR_W=2) share all inputs; each step checks against
// hand-computed words. Honours ENC_RANGE_CHECK_EN for the range cases.
module tb_instr_encoder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        load_end;
  logic        in_valid;
  logic [4:0]  in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop;
  logic [31:0] in_imm, in_target;

  logic        in_ready, imem_we, busy, done, err;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic [12:0] word_cnt;
  logic [1:0]  err_code, state_dbg;

  logic        s_in_ready, s_imem_we, s_busy, s_done, s_err;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_data;
  logic [2:0]  s_word_cnt;
  logic [1:0]  s_err_code, s_state_dbg;

  int checks = 0;
  int failures = 0;

  localparam logic [4:0] ADDI = 5'b00101;

  // clock/reset block
  always #5 clock = ~clock;

  instr_encoder #(.ADDR_W(12)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .load_end(load_end),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt),
    .in_aluop(in_aluop), .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
    .word_cnt(word_cnt), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .state_dbg(state_dbg)
  );

  instr_encoder #(.ADDR_W(2)) dut_s (
    .clock(clock), .reset_n(reset_n), .start(start), .load_end(load_end),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt),
    .in_aluop(in_aluop), .in_imm(in_imm), .in_target(in_target),
    .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_data(s_imem_data),
    .word_cnt(s_word_cnt), .busy(s_busy), .done(s_done), .err(s_err),
    .err_code(s_err_code), .state_dbg(s_state_dbg)
  );

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] alu,
                      input logic [31:0] imm, input logic [31:0] tgt);
    in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt;
    in_shamt = sh; in_aluop = alu; in_imm = imm; in_target = tgt;
    in_valid = 1'b1;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"},  32'(in_ready),  32'h0);
    check({tag, "_we"},     32'(imem_we),   32'h0);
    check({tag, "_addr"},   32'(imem_addr), 32'h0);
    check({tag, "_data"},   imem_data,      32'h0);
    check({tag, "_cnt"},    32'(word_cnt),  32'h0);
    check({tag, "_busy"},   32'(busy),      32'h0);
    check({tag, "_done"},   32'(done),      32'h0);
    check({tag, "_err"},    32'(err),       32'h0);
    check({tag, "_code"},   32'(err_code),  32'h0);
    check({tag, "_state"},  32'(state_dbg), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; load_end = 1'b0; in_valid = 1'b0;
    in_opcode = '0; in_rd = '0; in_rs = '0; in_rt = '0;
    in_shamt = '0; in_aluop = '0; in_imm = '0; in_target = '0;

    // reset values
    repeat (2) @(posedge clock);
    #1;
    check_reset("rst");
    reset_n = 1'b1;
    tick();
    check("idle_ready", 32'(in_ready), 32'h0);

    // start enters LOAD
    do_start();
    check("load_state", 32'(state_dbg), 32'h1);
    check("load_ready", 32'(in_ready), 32'h1);
    check("load_busy",  32'(busy),     32'h1);

    // addi rd=3 rs=1 imm=-5
    send(ADDI, 5'd3, 5'd1, 5'd0, 5'd0, 5'd0, -32'sd5, 32'h0);
    idle();
    check("addi_we",   32'(imem_we),   32'h1);
    check("addi_addr", 32'(imem_addr), 32'h0);
    check("addi_data", imem_data,      32'h28C3FFFB);
    tick();
    check("addi_we_off", 32'(imem_we),   32'h0);
    check("addi_cnt",    32'(word_cnt),  32'h1);
    check("addi_next",   32'(imem_addr), 32'h1);

    // back-to-back R-type add then sw
    do_start();
    send(5'b00000, 5'd2, 5'd3, 5'd4, 5'd0, 5'd0, 32'h0, 32'h0);
    check("r_we",   32'(imem_we),   32'h1);
    check("r_addr", 32'(imem_addr), 32'h0);
    check("r_data", imem_data,      32'h00864000);
    send(5'b00111, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 32'd16, 32'h0);
    idle();
    check("sw_we",   32'(imem_we),   32'h1);
    check("sw_addr", 32'(imem_addr), 32'h1);
    check("sw_data", imem_data,      32'h39400010);
    tick();
    check("b2b_cnt", 32'(word_cnt), 32'h2);
    check("b2b_we",  32'(imem_we),  32'h0);

    // immediate out of range
    do_start();
    send(ADDI, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0001_0000, 32'h0);
`ifdef ENC_RANGE_CHECK_EN
    check("immr_we",   32'(imem_we),  32'h0);
    check("immr_err",  32'(err),      32'h1);
    check("immr_code", 32'(err_code), 32'h2);
`else
    check("immt_we",   32'(imem_we),   32'h1);
    check("immt_addr", 32'(imem_addr), 32'h0);
    check("immt_data", imem_data,      32'h28410000);
    check("immt_err",  32'(err),       32'h0);
`endif
    send(ADDI, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 32'h1, 32'h0);
    idle();
    check("imm_next_we",   32'(imem_we), 32'h1);
`ifdef ENC_RANGE_CHECK_EN
    check("imm_next_addr", 32'(imem_addr), 32'h0);
`else
    check("imm_next_addr", 32'(imem_addr), 32'h1);
`endif
    check("imm_next_data", imem_data, 32'h28400001);
    tick();

    // bad opcode then over-range target: first error sticks
    do_start();
    send(5'b11111, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    check("badop_we",   32'(imem_we),  32'h0);
    check("badop_err",  32'(err),      32'h1);
    check("badop_code", 32'(err_code), 32'h1);
    send(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0800_0000);
    idle();
`ifdef ENC_RANGE_CHECK_EN
    check("tgt_we", 32'(imem_we), 32'h0);
`else
    check("tgt_we",   32'(imem_we),   32'h1);
    check("tgt_addr", 32'(imem_addr), 32'h0);
    check("tgt_data", imem_data,      32'h0800_0000);
`endif
    check("tgt_code", 32'(err_code), 32'h1);
    tick();
`ifdef ENC_RANGE_CHECK_EN
    check("tgt_cnt", 32'(word_cnt), 32'h0);
`else
    check("tgt_cnt", 32'(word_cnt), 32'h1);
`endif
    check("tgt_err", 32'(err), 32'h1);

    // load_end together with in_valid: pending write finishes, no accept
    do_start();
    send(ADDI, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 32'd7, 32'h0);
    check("le_we",   32'(imem_we), 32'h1);
    check("le_data", imem_data,    32'h28800007);
    load_end = 1'b1;
    #1;
    check("le_ready", 32'(in_ready), 32'h0);
    tick();
    load_end = 1'b0;
    idle();
    check("le_done",  32'(done),      32'h1);
    check("le_busy",  32'(busy),      32'h0);
    check("le_we2",   32'(imem_we),   32'h0);
    check("le_cnt",   32'(word_cnt),  32'h1);
    check("le_state", 32'(state_dbg), 32'h2);

    // small instance fills after four words
    do_start();
    for (int i = 0; i < 6; i++) begin
      send(ADDI, 5'(i), 5'd0, 5'd0, 5'd0, 5'd0, 32'(i), 32'h0);
      if (i < 4) begin
        check("full_we",   32'(s_imem_we),   32'h1);
        check("full_addr", 32'(s_imem_addr), 32'(i));
        check("full_data", s_imem_data,      32'h2800_0000 | (32'(i) << 22) | 32'(i));
      end else begin
        check("full_we_off", 32'(s_imem_we),    32'h0);
        check("full_done",   32'(s_done),       32'h1);
        check("full_ready",  32'(s_in_ready),   32'h0);
        check("full_cnt",    32'(s_word_cnt),   32'h4);
        check("full_wrap",   32'(s_imem_addr),  32'h0);
      end
    end
    idle();
    tick();

    // asynchronous reset mid-stream, then restart from address 0
    do_start();
    send(ADDI, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 32'h1, 32'h0);
    send(ADDI, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 32'h2, 32'h0);
    check("mid_we",   32'(imem_we),   32'h1);
    check("mid_addr", 32'(imem_addr), 32'h1);
    reset_n = 1'b0;
    idle();
    #1;
    check_reset("arst");
    tick();
    reset_n = 1'b1;
    tick();
    do_start();
    send(ADDI, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 32'h3, 32'h0);
    idle();
    check("rs_we",   32'(imem_we),   32'h1);
    check("rs_addr", 32'(imem_addr), 32'h0);
    check("rs_data", imem_data,      32'h28C00003);
    tick();

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
